// File: rtl/sample_msg_combiner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sample_msg_combiner_pkg
//  Description : Shared message word definitions for the sample/message
//                combiner and splitter: header-bit position, length-field
//                width and extraction helpers, arbiter and output-select
//                encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package sample_msg_combiner_pkg;

    // Width of the length field carried in a message header.
    localparam int MSG_LENGTH_WIDTH = 16;

    // Widest stream word the helpers accept; callers zero-extend into it.
    localparam int MSG_WORD_MAX = 64;

    typedef logic [MSG_WORD_MAX-1:0] msg_word_t;

    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_MSG  = 1'b1;

    localparam logic [1:0] SEL_NONE   = 2'd0;
    localparam logic [1:0] SEL_SAMPLE = 2'd1;
    localparam logic [1:0] SEL_MSG    = 2'd2;

    // Bit index of the header flag for a stream of the given width.
    function automatic int msg_hdr_bit(input int width);
        return width - 1;
    endfunction

    function automatic logic msg_is_header(input msg_word_t w, input int width);
        msg_word_t tmp;
        tmp = w >> msg_hdr_bit(width);
        return tmp[0];
    endfunction

    // Length field sits directly below the header flag.
    function automatic logic [MSG_LENGTH_WIDTH-1:0] msg_length(input msg_word_t w,
                                                               input int width);
        msg_word_t tmp;
        tmp = w >> (msg_hdr_bit(width) - MSG_LENGTH_WIDTH);
        return tmp[MSG_LENGTH_WIDTH-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sample_msg_combiner_msg_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : msg_fifo
//  Description : Synchronous FIFO with registered single-cycle read, head
//                peek, full/empty flags and fill count. A write to a full
//                FIFO is accepted only when a read happens in the same cycle.
//  Ports       : clk, rst_n (sync, active-low), wr_en_i/wr_data_i,
//                rd_en_i -> rd_data_o (valid after the read edge),
//                head_o (combinational peek), full_o, empty_o, count_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module msg_fifo #(
    parameter int WIDTH     = 32,
    parameter int LOG_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en_i,
    input  logic [WIDTH-1:0]     wr_data_i,
    input  logic                 rd_en_i,
    output logic [WIDTH-1:0]     rd_data_o,
    output logic [WIDTH-1:0]     head_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [LOG_DEPTH:0]   count_o
);
    localparam int DEPTH = 1 << LOG_DEPTH;

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr_q;
    logic [LOG_DEPTH-1:0] rd_ptr_q;
    logic [LOG_DEPTH:0]   count_q;
    logic [WIDTH-1:0]     rd_data_q;
    logic                 w_rd;
    logic                 w_wr;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == (LOG_DEPTH+1)'(DEPTH));
    assign count_o   = count_q;
    assign head_o    = mem_q[rd_ptr_q];
    assign rd_data_o = rd_data_q;

    // Read frees a slot before the write lands, so full + read + write is legal.
    assign w_rd = rd_en_i && !empty_o;
    assign w_wr = wr_en_i && (!full_o || w_rd);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            if (w_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_rd) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                rd_data_q <= mem_q[rd_ptr_q];
            end
            case ({w_wr, w_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule
`default_nettype wire

// File: rtl/sample_msg_combiner.sv
`default_nettype none
// ============================================================================
//  Module      : sample_msg_combiner
//  Description : Merges a sample stream and a framed message stream into one
//                output stream. Messages are emitted contiguously; samples
//                fill the gaps. Malformed or overflowing words are dropped
//                and raise a sticky error.
//  Ports       : clk, rst_n (sync, active-low),
//                in_samples/in_samples_nd, in_msg/in_msg_nd,
//                out_data/out_nd (registered), error (sticky).
//  Config      : SAMPLE_MSG_COMBINER_MSG_PRIORITY_EN - defined: ready message
//                always beats samples; undefined: round-robin grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_msg_combiner
    import sample_msg_combiner_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int SAMPLE_BUF_LOG = 4,
    parameter int MSG_BUF_LOG    = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_samples,
    input  logic             in_samples_nd,
    input  logic [WIDTH-1:0] in_msg,
    input  logic             in_msg_nd,
    output logic [WIDTH-1:0] out_data,
    output logic             out_nd,
    output logic             error
);
    // FIFO interfaces
    logic                    smp_wr, smp_rd, smp_full, smp_empty;
    logic [WIDTH-1:0]        smp_rd_data, smp_head;
    logic [SAMPLE_BUF_LOG:0] smp_count;
    logic                    msg_wr, msg_rd, msg_full, msg_empty;
    logic [WIDTH-1:0]        msg_rd_data, msg_head;
    logic [MSG_BUF_LOG:0]    msg_count;

    // Input tracker
    logic [MSG_LENGTH_WIDTH-1:0] expect_q, expect_d;
    logic                        skip_q, skip_d;
    logic                        msg_err, smp_err;
    logic                        w_in_hdr, w_len_too_big, w_msg_space;
    logic [MSG_LENGTH_WIDTH-1:0] w_in_len;

    // Arbiter
    logic [0:0]                  state_q, state_d;
    logic [MSG_LENGTH_WIDTH-1:0] remaining_q, remaining_d;
    logic                        grant_q, grant_d;   // 1: last grant was a message
    logic                        w_head_hdr, w_msg_ready, w_grant_msg;
    logic [MSG_LENGTH_WIDTH-1:0] w_head_len;
    logic [1:0]                  sel_q, sel_d;

    logic [WIDTH-1:0]            out_data_q;
    logic                        out_nd_q, error_q;

    msg_fifo #(.WIDTH(WIDTH), .LOG_DEPTH(SAMPLE_BUF_LOG)) u_sample_fifo (
        .clk(clk), .rst_n(rst_n),
        .wr_en_i(smp_wr), .wr_data_i(in_samples), .rd_en_i(smp_rd),
        .rd_data_o(smp_rd_data), .head_o(smp_head),
        .full_o(smp_full), .empty_o(smp_empty), .count_o(smp_count)
    );

    msg_fifo #(.WIDTH(WIDTH), .LOG_DEPTH(MSG_BUF_LOG)) u_msg_fifo (
        .clk(clk), .rst_n(rst_n),
        .wr_en_i(msg_wr), .wr_data_i(in_msg), .rd_en_i(msg_rd),
        .rd_data_o(msg_rd_data), .head_o(msg_head),
        .full_o(msg_full), .empty_o(msg_empty), .count_o(msg_count)
    );

    // ---------------- sample input ----------------
    assign smp_wr  = in_samples_nd && !in_samples[WIDTH-1] && (!smp_full || smp_rd);
    assign smp_err = in_samples_nd && (in_samples[WIDTH-1] || (smp_full && !smp_rd));

    // ---------------- message input tracker ----------------
    assign w_in_hdr      = msg_is_header(msg_word_t'(in_msg), WIDTH);
    assign w_in_len      = msg_length(msg_word_t'(in_msg), WIDTH);
    assign w_len_too_big = (32'(w_in_len) + 32'd1) > (32'd1 << MSG_BUF_LOG);
    assign w_msg_space   = !msg_full || msg_rd;

    always_comb begin
        expect_d = expect_q;
        skip_d   = skip_q;
        msg_wr   = 1'b0;
        msg_err  = 1'b0;
        if (in_msg_nd) begin
            if (w_in_hdr) begin
                if ((expect_q != '0) || w_len_too_big) begin
                    msg_err = 1'b1;               // dropped, tracker unchanged
                end else begin
                    expect_d = w_in_len;
                    if (w_msg_space) begin
                        msg_wr = 1'b1;
                        skip_d = 1'b0;
                    end else begin
                        msg_err = 1'b1;           // header lost: discard its body
                        skip_d  = (w_in_len != '0);
                    end
                end
            end else if (expect_q == '0) begin
                msg_err = 1'b1;
            end else begin
                expect_d = expect_q - 1'b1;
                if (!skip_q && w_msg_space) msg_wr = 1'b1;
                if (!skip_q && !w_msg_space) msg_err = 1'b1;
                // Once any word is lost, the rest of the message is skipped.
                skip_d = (skip_q || !w_msg_space) && (expect_q != 1);
            end
        end
    end

    // ---------------- output arbiter ----------------
    assign w_head_hdr  = msg_is_header(msg_word_t'(msg_head), WIDTH);
    assign w_head_len  = msg_length(msg_word_t'(msg_head), WIDTH);
    assign w_msg_ready = !msg_empty && w_head_hdr &&
                         (32'(msg_count) >= 32'(w_head_len) + 32'd1);

`ifdef SAMPLE_MSG_COMBINER_MSG_PRIORITY_EN
    assign w_grant_msg = w_msg_ready;
`else
    assign w_grant_msg = w_msg_ready && (smp_empty || !grant_q);
`endif

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            remaining_q <= '0;
            grant_q     <= 1'b0;
            expect_q    <= '0;
            skip_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            grant_q     <= grant_d;
            expect_q    <= expect_d;
            skip_q      <= skip_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        grant_d     = grant_q;
        case (state_q)
            ARB_IDLE: begin
                if (w_grant_msg) begin
                    remaining_d = w_head_len;
                    grant_d     = 1'b1;
                    if (w_head_len != '0) state_d = ARB_MSG;
                end else if (!smp_empty) begin
                    grant_d = 1'b0;
                end
            end
            ARB_MSG: begin
                remaining_d = remaining_q - 1'b1;
                if (remaining_q == 1) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // output logic: FIFO read strobes and the source of next cycle's word
    always_comb begin
        msg_rd = 1'b0;
        smp_rd = 1'b0;
        sel_d  = SEL_NONE;
        case (state_q)
            ARB_IDLE: begin
                if (w_grant_msg) begin
                    msg_rd = 1'b1;
                    sel_d  = SEL_MSG;
                end else if (!smp_empty) begin
                    smp_rd = 1'b1;
                    sel_d  = SEL_SAMPLE;
                end
            end
            ARB_MSG: begin
                msg_rd = 1'b1;
                sel_d  = SEL_MSG;
            end
            default: ;
        endcase
    end

    // Second stage: FIFO read data is registered, then landed on the output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q      <= SEL_NONE;
            out_data_q <= '0;
            out_nd_q   <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            sel_q    <= sel_d;
            out_nd_q <= (sel_q != SEL_NONE);
            case (sel_q)
                SEL_MSG:    out_data_q <= msg_rd_data;
                SEL_SAMPLE: out_data_q <= smp_rd_data;
                default:    out_data_q <= '0;
            endcase
            error_q <= error_q | msg_err | smp_err;
        end
    end

    assign out_data = out_data_q;
    assign out_nd   = out_nd_q;
    assign error    = error_q;

endmodule
`default_nettype wire

// File: tb/tb_sample_msg_combiner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sample_msg_combiner
//  Description : Directed self-checking bench for sample_msg_combiner.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_msg_combiner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_samples, in_msg;
    logic        in_samples_nd, in_msg_nd;
    logic [31:0] out_data;
    logic        out_nd, error;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic [31:0] outq[$];
    int          outcyc[$];

    always #5 clk = ~clk;

    sample_msg_combiner #(.WIDTH(32), .SAMPLE_BUF_LOG(4), .MSG_BUF_LOG(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_samples(in_samples), .in_samples_nd(in_samples_nd),
        .in_msg(in_msg), .in_msg_nd(in_msg_nd),
        .out_data(out_data), .out_nd(out_nd), .error(error)
    );

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (out_nd) begin
            outq.push_back(out_data);
            outcyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic s_nd, input logic [31:0] s,
                         input logic m_nd, input logic [31:0] m);
        in_samples_nd = s_nd;
        in_samples    = s;
        in_msg_nd     = m_nd;
        in_msg        = m;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        outq.delete();
        outcyc.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, sidx, n, waited;
        logic [31:0] exp3 [6];

        // ---- reset values and single-sample latency ----
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        do_reset();
        chk("rst_out_nd", 32'(out_nd), 32'd0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_error", 32'(error), 32'd0);

        drive(1'b1, 32'h0000_0005, 1'b0, 32'h0);
        tick();                                   // edge t
        idle(1);                                  // edge t+1
        chk("lat_nd_t1", 32'(out_nd), 32'd0);
        tick();                                   // edge t+2
        chk("lat_nd_t2", 32'(out_nd), 32'd1);
        chk("lat_data_t2", out_data, 32'h0000_0005);
        chk("lat_error", 32'(error), 32'd0);

        // ---- message L=2 while samples stream every cycle ----
        do_reset();
        for (int k = 0; k < 6; k++) begin
            case (k)
                0: drive(1'b1, 32'h100 + k, 1'b1, 32'h8001_0000);
                1: drive(1'b1, 32'h100 + k, 1'b1, 32'h0000_000A);
                2: drive(1'b1, 32'h100 + k, 1'b1, 32'h0000_000B);
                default: drive(1'b1, 32'h100 + k, 1'b0, 32'h0);
            endcase
            tick();
        end
        idle(20);
        chk("mix_count", 32'(outq.size()), 32'd9);
        hi = -1;
        foreach (outq[i]) if (outq[i] == 32'h8001_0000) hi = i;
        chk("mix_hdr_found", 32'(hi >= 0 && hi + 2 < outq.size()), 32'd1);
        if (hi >= 0 && hi + 2 < outq.size()) begin
            chk("mix_content0", outq[hi+1], 32'h0000_000A);
            chk("mix_content1", outq[hi+2], 32'h0000_000B);
            chk("mix_contiguous", 32'(outcyc[hi+2] - outcyc[hi]), 32'd2);
        end
        sidx = 0;
        foreach (outq[i]) begin
            if (outq[i] >= 32'h100 && outq[i] < 32'h200) begin
                chk("mix_sample_order", outq[i], 32'h100 + sidx);
                sidx++;
            end
        end
        chk("mix_sample_count", 32'(sidx), 32'd6);
        chk("mix_error", 32'(error), 32'd0);

        // ---- grant policy: three L=0 messages vs three samples ----
        do_reset();
        drive(1'b1, 32'h11, 1'b1, 32'h8000_0001); tick();
        drive(1'b1, 32'h12, 1'b1, 32'h8000_0002); tick();
        drive(1'b1, 32'h13, 1'b1, 32'h8000_0003); tick();
        idle(15);
`ifdef SAMPLE_MSG_COMBINER_MSG_PRIORITY_EN
        exp3 = '{32'h8000_0001, 32'h8000_0002, 32'h8000_0003, 32'h11, 32'h12, 32'h13};
`else
        exp3 = '{32'h8000_0001, 32'h11, 32'h8000_0002, 32'h12, 32'h8000_0003, 32'h13};
`endif
        chk("grant_count", 32'(outq.size()), 32'd6);
        for (int i = 0; i < 6 && i < outq.size(); i++) chk("grant_order", outq[i], exp3[i]);

        // ---- protocol errors: orphan content, oversized header ----
        do_reset();
        chk("perr_clear", 32'(error), 32'd0);
        drive(1'b0, 32'h0, 1'b1, 32'h0000_0077); tick();
        idle(1);
        chk("perr_orphan", 32'(error), 32'd1);
        drive(1'b0, 32'h0, 1'b1, 32'h8020_0000); tick();   // L = 64
        drive(1'b0, 32'h0, 1'b1, 32'h8000_8000); tick();   // L = 1
        drive(1'b0, 32'h0, 1'b1, 32'h0000_0055); tick();
        idle(6);
        drive(1'b1, 32'h200, 1'b0, 32'h0); tick();
        idle(8);
        chk("perr_count", 32'(outq.size()), 32'd3);
        if (outq.size() == 3) begin
            chk("perr_hdr", outq[0], 32'h8000_8000);
            chk("perr_content", outq[1], 32'h0000_0055);
            chk("perr_sample", outq[2], 32'h0000_0200);
        end
        chk("perr_sticky", 32'(error), 32'd1);

        // ---- sample overflow behind a 16-word message ----
        do_reset();
        for (int i = 0; i < 32; i++) begin
            drive(i >= 15, 32'h300 + (i - 15),
                  i < 16, (i == 0) ? 32'h8007_8000 : 32'h1000 + i);
            tick();
        end
        idle(40);
        chk("ovf_count", 32'(outq.size()), 32'd32);
        if (outq.size() == 32) begin
            chk("ovf_hdr", outq[0], 32'h8007_8000);
            chk("ovf_last_content", outq[15], 32'h0000_100F);
            chk("ovf_first_sample", outq[16], 32'h0000_0300);
            chk("ovf_last_sample", outq[31], 32'h0000_030F);
        end
        chk("ovf_error", 32'(error), 32'd1);

        // ---- reset in the middle of a message ----
        do_reset();
        drive(1'b0, 32'h0, 1'b1, 32'h0000_0077); tick();   // sets error
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 32'h0, 1'b1, (i == 0) ? 32'h8003_8000 : 32'h2000 + i);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        waited = 0;
        while (!(out_nd && out_data == 32'h8003_8000) && waited < 50) begin
            tick();
            waited++;
        end
        chk("mrst_hdr_seen", 32'(waited < 50), 32'd1);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("mrst_out_nd", 32'(out_nd), 32'd0);
        chk("mrst_out_data", out_data, 32'h0);
        chk("mrst_error", 32'(error), 32'd0);
        rst_n = 1'b1;
        n = outq.size();
        idle(20);
        chk("mrst_no_more_output", 32'(outq.size()), 32'(n));
        chk("mrst_error_after", 32'(error), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sample_msg_combiner.md
SAMPLE_MSG_COMBINER -- requirements
Module: sample_msg_combiner

Interface
REQ-001 Parameters SHALL be: WIDTH, 32, word width; SAMPLE_BUF_LOG, 4, log2 sample buffer depth; MSG_BUF_LOG, 6, log2 message buffer depth.
REQ-002 Ports SHALL be, in this order:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; synchronous and active-low.
- in_samples  in  WIDTH  sample word.
- in_samples_nd  in  1  in_samples valid this cycle.
- in_msg  in  WIDTH  message header or content word.
- in_msg_nd  in  1  in_msg valid this cycle.
- out_data  out  WIDTH  merged stream word.
- out_nd  out  1  out_data valid this cycle.
- error  out  1  sticky protocol or overflow error.

Function
REQ-003 The block SHALL merge the sample and message streams into one stream that sample_msg_splitter parses back exactly; neither input has backpressure.
REQ-004 Samples SHALL be buffered in a 2^SAMPLE_BUF_LOG-word FIFO; accepted message words SHALL be buffered in a 2^MSG_BUF_LOG-word FIFO.
REQ-005 Input tracker: a header is bit WIDTH-1 = 1, its length L is bits [WIDTH-2 -: MSG_LENGTH_WIDTH], and the tracker then expects L content words (bit WIDTH-1 = 0).
REQ-006 The following words SHALL be dropped and SHALL set error, while tracker state is kept:
- a header arriving while contents are still expected;
- a content word arriving when no contents are expected;
- a header with L+1 > 2^MSG_BUF_LOG.
REQ-007 A sample word with bit WIDTH-1 = 1 SHALL be dropped and SHALL set error.
REQ-008 A write to a full FIFO SHALL drop the word and set error. A dropped message word SHALL also drop the rest of that message, and the tracker SHALL skip its remaining contents.
REQ-009 A message is ready when the message FIFO head is a header and the FIFO fill is at least L+1.
REQ-010 The output arbiter SHALL have two states, IDLE and MSG.
- IDLE with a ready message and a grant: emit the header, load remaining = L, go to MSG if L > 0.
- IDLE otherwise with the sample FIFO non-empty: emit one sample.
- MSG: emit one content word per cycle, decrement remaining, return to IDLE after the last content word.
REQ-011 A message SHALL be emitted contiguously: no samples are interleaved and there are no gaps.
REQ-012 Output SHALL be registered, with at most one word per cycle. out_nd SHALL be low in any cycle with nothing emitted.
REQ-013 Latency: a word written with both FIFOs empty, in IDLE, at edge t SHALL appear on out_data with out_nd high after edge t+2.
REQ-014 Simultaneous in_samples_nd and in_msg_nd SHALL both be accepted in the same cycle.
REQ-015 A FIFO SHALL accept a write while being read when full (read-before-write); its fill SHALL be unchanged.
REQ-016 A message with L = 0 SHALL emit the header only and the arbiter SHALL stay in IDLE.

Reset
REQ-017 When rst_n is low at a clock edge, the block SHALL:
- empty both FIFOs;
- return the tracker and the arbiter to IDLE;
- clear the grant pointer;
- drive out_nd = 0, out_data = 0 and error = 0.
REQ-018 A reset asserted mid-message SHALL abort the message immediately; no further contents of it are emitted.

Configuration
REQ-019 Macro SAMPLE_MSG_COMBINER_MSG_PRIORITY_EN controls the IDLE-state grant:
- Defined: a ready message always wins over samples.
- Undefined: round-robin. After a message, a pending sample wins. After a sample, a ready message wins.

Structure
REQ-020 MSG_LENGTH_WIDTH, the header-bit index and the length-field extraction SHALL live in the shared message definitions file used by the splitter.
REQ-021 Both buffers SHALL be instances of one sub-module, msg_fifo, with parameters WIDTH and LOG_DEPTH. It SHALL provide a single-cycle synchronous read, a head-word peek, full and empty flags, and a fill count.

Verification
REQ-022 Test: single sample 0x00000005 after reset -> out_data 0x00000005 with out_nd high 2 cycles later, and error = 0.
REQ-023 Test: header L=2, then contents 0xA and 0xB, while samples arrive every cycle -> header, 0xA and 0xB appear back-to-back and all samples are preserved in order.
REQ-024 Test: a ready message and pending samples, run with and without SAMPLE_MSG_COMBINER_MSG_PRIORITY_EN -> priority order versus strict alternation, respectively.
REQ-025 Test: content word with no open message, and a header with L = 2^MSG_BUF_LOG -> both dropped, error = 1, and later traffic is correct.
REQ-026 Test: 17 samples in 17 cycles while a 16-word message blocks output (SAMPLE_BUF_LOG = 4) -> overflow drop and error = 1.
REQ-027 Test: rst_n low during the MSG state -> out_nd = 0 from the next cycle, FIFOs empty and error = 0.
